seq_addsub_acc: RTL and testbench
=================================

// Module: seq_addsub_acc
// PURPOSE
//  Parametrised multi-cycle two's-complement add/subtract unit with an accumulate mode.
//  Processes WIDTH-bit operands SLICE bits per clock, rippling the carry through a registered
//  carry flop between slices. Raises per-operation overflow and carry-out, and keeps a sticky
//  overflow flag. Sits between the switch/operand inputs and the seven-segment display decoders.
// PARAMETERS
//  WIDTH   8  operand/result width in bits; must be a multiple of SLICE
//  SLICE   4  bits added per clock; 1 <= SLICE <= WIDTH
// PORTS
//  Clk        in   1      rising-edge clock
//  Reset      in   1      synchronous, active-high reset
//  Start      in   1      request an operation; sampled only in IDLE
//  AddSub     in   1      0 = add, 1 = subtract (first operand minus B)
//  AccMode    in   1      0: first operand = A; 1: first operand = current S
//  A          in   WIDTH  first operand (signed)
//  B          in   WIDTH  second operand (signed)
//  ClrSticky  in   1      clear OvrSticky
//  Busy       out  1      high in CALC and DONE
//  Done       out  1      one-cycle pulse when S/Cout/OVR update
//  S          out  WIDTH  registered result; holds until the next completion
//  Cout       out  1      carry out of the MSB for the last operation
//  OVR        out  1      signed overflow for the last operation
//  OvrSticky  out  1      set by any overflow, held until ClrSticky or Reset
// BEHAVIOUR
//  - Reset (highest priority, any state): state=IDLE; S, Cout, OVR, OvrSticky, Busy, Done = 0;
//    slice counter = 0. Reset during CALC aborts the operation and produces no Done.
//  - FSM IDLE -> CALC -> DONE -> IDLE. N = WIDTH/SLICE.
//  - IDLE with Start=1: latch opA = AccMode ? S : A, and opB = B ^ {WIDTH{AddSub}}.
//    Set carry = AddSub and slice index = 0, then go to CALC. With Start=0, stay in IDLE.
//  - CALC: each cycle computes {c, r} = opA[k] + opB[k] + carry for slice k (SLICE bits).
//    It stores r into the result shadow register and c into carry. On the MSB slice it also
//    records the carry into bit WIDTH-1. After N cycles it goes to DONE.
//  - DONE (one cycle): S <= shadow; Cout <= final carry; OVR <= carry into MSB ^ carry out of
//    MSB; Done = 1; then IDLE.
//  - Latency: Start sampled at edge t -> Done high during cycle t+N+1. Minimum Start-to-Start
//    spacing is N+2 cycles.
//  - Start while Busy=1 is ignored, not queued. A, B, AddSub and AccMode may change after the
//    Start edge without affecting the operation.
//  - Arithmetic is modulo 2^WIDTH. Cout is the raw carry (for subtract, Cout=1 means no borrow).
//  - OvrSticky: set in DONE when OVR computes 1. ClrSticky clears it in any state.
//    If set and clear occur in the same cycle, set wins.
//  - AccMode with AddSub=1 computes S - B. With AccMode=1 after Reset, S starts at 0.
// TESTING
//  1. W=8,SL=4: A=0x7F, B=0x01, add. Start at t -> Done at t+3; S=0x80, OVR=1, Cout=0, OvrSticky=1.
//  2. W=8,SL=4: A=0x05, B=0x07, sub -> S=0xFE (-2), OVR=0, Cout=0. Then A=0x80, B=0x01, sub ->
//     S=0x7F, OVR=1, Cout=1.
//  3. Accumulate: A=0x10 add B=0x00 -> S=0x10. Then AccMode=1, B=0x20, add -> S=0x30.
//     Then AccMode=1, B=0x05, sub -> S=0x2B.
//  4. Start pulsed again in each CALC/DONE cycle of an operation -> exactly one Done, S unchanged
//     by the extra pulses. ClrSticky together with an overflowing DONE -> OvrSticky stays 1.
//  5. Reset asserted in the 2nd CALC cycle -> next cycle: IDLE, S=0, no Done. A fresh Start then
//     completes normally.
//  6. W=8,SL=1 and W=8,SL=8: random 1000 ops vs reference model (S, Cout, OVR);
//     latency = 9 and 2 cycles respectively.

Source files
------------

// File: rtl/seq_addsub_acc.sv
// ============================================================================
//  Module      : seq_addsub_acc
//  Description : Multi-cycle two's-complement add/subtract with accumulate
//                mode; SLICE bits per clock, carry rippled through a flop.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_addsub_acc #(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             AddSub,
    input  logic             AccMode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             ClrSticky,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             OVR,
    output logic             OvrSticky
);

    localparam int N_SLICES = WIDTH / SLICE;
    localparam int IDX_W    = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLICES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cmsb_q, cmsb_d;
    logic             cout_q, cout_d;
    logic             ovr_q, ovr_d;
    logic             sticky_q, sticky_d;
    logic             done_q, done_d;

    logic [SLICE-1:0] slice_a, slice_b, slice_r;
    logic             slice_c;
    logic             slice_cin_msb;

    always_comb begin
        slice_a = opa_q[idx_q * SLICE +: SLICE];
        slice_b = opb_q[idx_q * SLICE +: SLICE];
        {slice_c, slice_r} = {1'b0, slice_a} + {1'b0, slice_b} + {{SLICE{1'b0}}, carry_q};
        // Carry into the top bit recovered from the sum bit: c_in = a ^ b ^ r.
        slice_cin_msb = slice_a[SLICE-1] ^ slice_b[SLICE-1] ^ slice_r[SLICE-1];
    end

    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        shadow_d = shadow_q;
        s_d      = s_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        cmsb_d   = cmsb_q;
        cout_d   = cout_q;
        ovr_d    = ovr_q;
        sticky_d = ClrSticky ? 1'b0 : sticky_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    opa_d   = AccMode ? s_q : A;
                    opb_d   = B ^ {WIDTH{AddSub}};
                    carry_d = AddSub;
                    idx_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                shadow_d[idx_q * SLICE +: SLICE] = slice_r;
                carry_d = slice_c;
                if (idx_q == LAST_IDX) begin
                    cmsb_d  = slice_cin_msb;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                s_d    = shadow_q;
                cout_d = carry_q;
                ovr_d  = cmsb_q ^ carry_q;
                // Setting takes precedence over a simultaneous clear.
                if (cmsb_q ^ carry_q) begin
                    sticky_d = 1'b1;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            shadow_q <= '0;
            s_q      <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            cmsb_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovr_q    <= 1'b0;
            sticky_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            shadow_q <= shadow_d;
            s_q      <= s_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            cmsb_q   <= cmsb_d;
            cout_q   <= cout_d;
            ovr_q    <= ovr_d;
            sticky_q <= sticky_d;
            done_q   <= done_d;
        end
    end

    assign Busy      = (state_q != ST_IDLE);
    assign Done      = done_q;
    assign S         = s_q;
    assign Cout      = cout_q;
    assign OVR       = ovr_q;
    assign OvrSticky = sticky_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_addsub_acc.sv
// ============================================================================
//  Module      : tb_seq_addsub_acc
//  Description : Scoreboard bench for seq_addsub_acc at SLICE = 4, 1 and 8.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_addsub_acc;

    typedef struct {
        logic [7:0] s;
        logic       cout;
        logic       ovr;
        logic       sticky;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i   [3];
    logic       addsub_i  [3];
    logic       accmode_i [3];
    logic       clr_i     [3];
    logic [7:0] a_i       [3];
    logic [7:0] b_i       [3];
    logic       busy_o    [3];
    logic       done_o    [3];
    logic [7:0] s_o       [3];
    logic       cout_o    [3];
    logic       ovr_o     [3];
    logic       sticky_o  [3];

    exp_t       exp_q [3][$];
    logic [7:0] m_s      [3];
    logic       m_sticky [3];
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    exp_t       mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        seq_addsub_acc #(
            .WIDTH (8),
            .SLICE ((g == 0) ? 4 : ((g == 1) ? 1 : 8))
        ) u_dut (
            .Clk       (clk),
            .Reset     (rst),
            .Start     (start_i[g]),
            .AddSub    (addsub_i[g]),
            .AccMode   (accmode_i[g]),
            .A         (a_i[g]),
            .B         (b_i[g]),
            .ClrSticky (clr_i[g]),
            .Busy      (busy_o[g]),
            .Done      (done_o[g]),
            .S         (s_o[g]),
            .Cout      (cout_o[g]),
            .OVR       (ovr_o[g]),
            .OvrSticky (sticky_o[g])
        );
    end

    function automatic int sl_of(int d);
        return (d == 0) ? 4 : ((d == 1) ? 1 : 8);
    endfunction

    task automatic chk(string name, int d, logic [31:0] act, logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h (cycle %0d)", name, d, act, expv, cyc);
        end
    endtask

    // Monitor: every Done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (done_o[d] === 1'b1) begin
                if (exp_q[d].size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done dut%0d: got Done=1, expected no Done (cycle %0d)", d, cyc);
                end else begin
                    mon_e = exp_q[d].pop_front();
                    chk("S",         d, 32'(s_o[d]),      32'(mon_e.s));
                    chk("Cout",      d, 32'(cout_o[d]),   32'(mon_e.cout));
                    chk("OVR",       d, 32'(ovr_o[d]),    32'(mon_e.ovr));
                    chk("OvrSticky", d, 32'(sticky_o[d]), 32'(mon_e.sticky));
                    chk("latency",   d, 32'(cyc),         32'(mon_e.cyc));
                end
            end
        end
    end

    // Called at a negedge; drives one Start edge and predicts the result.
    task automatic issue(int d, bit acc, bit sub, logic [7:0] a, logic [7:0] b, bit clr, bit track);
        exp_t       e;
        logic [7:0] opa;
        int         ua, ub, sa, sb, sr;
        start_i[d]   = 1'b1;
        accmode_i[d] = acc;
        addsub_i[d]  = sub;
        a_i[d]       = a;
        b_i[d]       = b;
        clr_i[d]     = clr;
        if (track) begin
            opa = acc ? m_s[d] : a;
            ua  = int'(opa);
            ub  = int'(b);
            sa  = (ua > 127) ? ua - 256 : ua;
            sb  = (ub > 127) ? ub - 256 : ub;
            if (sub) begin
                sr     = sa - sb;
                e.s    = 8'(ua - ub);
                e.cout = (ua >= ub);
            end else begin
                sr     = sa + sb;
                e.s    = 8'(ua + ub);
                e.cout = (ua + ub > 255);
            end
            e.ovr = (sr > 127) || (sr < -128);
            if (clr) m_sticky[d] = 1'b0;
            if (e.ovr) m_sticky[d] = 1'b1;
            e.sticky = m_sticky[d];
            e.cyc    = cyc + 8 / sl_of(d) + 2;
            m_s[d]   = e.s;
            exp_q[d].push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        start_i[d]   = 1'b0;
        clr_i[d]     = 1'b0;
        a_i[d]       = 8'($urandom);
        b_i[d]       = 8'($urandom);
        addsub_i[d]  = 1'($urandom);
        accmode_i[d] = 1'($urandom);
        chk("busy_after_start", d, 32'(busy_o[d]), 32'd1);
    endtask

    task automatic wait_done(int d);
        int k;
        for (k = 0; k < 40; k++) begin
            if (done_o[d] === 1'b1) break;
            @(negedge clk);
        end
        vectors++;
        if (done_o[d] !== 1'b1) begin
            miscompares++;
            $display("FAIL done_timeout dut%0d: got no Done in 40 cycles, expected Done (cycle %0d)", d, cyc);
        end
    endtask

    task automatic reset_model();
        for (int d = 0; d < 3; d++) begin
            m_s[d]      = 8'h00;
            m_sticky[d] = 1'b0;
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            start_i[d] = 1'b0; addsub_i[d] = 1'b0; accmode_i[d] = 1'b0;
            clr_i[d] = 1'b0; a_i[d] = 8'h00; b_i[d] = 8'h00;
        end
        reset_model();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_S",      d, 32'(s_o[d]),      32'd0);
            chk("rst_Cout",   d, 32'(cout_o[d]),   32'd0);
            chk("rst_OVR",    d, 32'(ovr_o[d]),    32'd0);
            chk("rst_sticky", d, 32'(sticky_o[d]), 32'd0);
            chk("rst_Busy",   d, 32'(busy_o[d]),   32'd0);
            chk("rst_Done",   d, 32'(done_o[d]),   32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Signed overflow on add
        issue(0, 0, 0, 8'h7F, 8'h01, 0, 1);
        wait_done(0);
        chk("t1_S", 0, 32'(s_o[0]), 32'h80);
        chk("t1_sticky", 0, 32'(sticky_o[0]), 32'd1);

        // Subtract with borrow, then overflowing subtract
        issue(0, 0, 1, 8'h05, 8'h07, 0, 1);
        wait_done(0);
        chk("t2a_S", 0, 32'(s_o[0]), 32'hFE);
        issue(0, 0, 1, 8'h80, 8'h01, 0, 1);
        wait_done(0);
        chk("t2b_S", 0, 32'(s_o[0]), 32'h7F);
        chk("t2b_Cout", 0, 32'(cout_o[0]), 32'd1);

        // Accumulate chain
        issue(0, 0, 0, 8'h10, 8'h00, 0, 1);
        wait_done(0);
        issue(0, 1, 0, 8'hAA, 8'h20, 0, 1);
        wait_done(0);
        chk("t3_acc_add", 0, 32'(s_o[0]), 32'h30);
        issue(0, 1, 1, 8'h55, 8'h05, 0, 1);
        wait_done(0);
        chk("t3_acc_sub", 0, 32'(s_o[0]), 32'h2B);

        // Start pulses while busy are ignored
        issue(0, 0, 0, 8'h11, 8'h22, 0, 1);
        for (int i = 0; i < 3; i++) begin
            start_i[0] = 1'b1;
            a_i[0]     = 8'($urandom);
            b_i[0]     = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        start_i[0] = 1'b0;
        wait_done(0);
        repeat (5) @(negedge clk);
        chk("t4_S_held", 0, 32'(s_o[0]), 32'h33);
        chk("t4_idle", 0, 32'(busy_o[0]), 32'd0);

        // Clear requested across an overflowing completion: set wins
        clr_i[0] = 1'b1;
        @(negedge clk);
        m_sticky[0] = 1'b0;
        chk("t4_clr_idle", 0, 32'(sticky_o[0]), 32'd0);
        issue(0, 0, 0, 8'h40, 8'h40, 1, 1);
        clr_i[0] = 1'b1;
        wait_done(0);
        chk("t4_set_wins", 0, 32'(sticky_o[0]), 32'd1);
        @(negedge clk);
        clr_i[0] = 1'b0;
        m_sticky[0] = 1'b0;
        chk("t4_cleared", 0, 32'(sticky_o[0]), 32'd0);

        // Reset in the second CALC cycle aborts without a Done
        issue(0, 0, 0, 8'h01, 8'h02, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        chk("t5_busy", 0, 32'(busy_o[0]), 32'd0);
        chk("t5_S",    0, 32'(s_o[0]),    32'd0);
        chk("t5_done", 0, 32'(done_o[0]), 32'd0);
        repeat (6) @(negedge clk);
        issue(0, 1, 0, 8'hFF, 8'h09, 0, 1);
        wait_done(0);
        chk("t5_fresh", 0, 32'(s_o[0]), 32'h09);

        // Random operations on the bit-serial and single-cycle variants
        for (int d = 1; d < 3; d++) begin
            repeat (1000) begin
                issue(d, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                      ($urandom_range(0, 7) == 0), 1);
                wait_done(d);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        repeat (12) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("outstanding", d, 32'(exp_q[d].size()), 32'd0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
